// File: rtl/full_handshake_tx_pkg.sv
// Shared constants and helpers for the four-phase transmit side.
// State encoding: IDLE=01, ASSERT=10, DEASSERT=11; 00 is unused and recovers to IDLE.
package full_handshake_tx_pkg;

    localparam logic [1:0] ST_IDLE     = 2'b01;
    localparam logic [1:0] ST_ASSERT   = 2'b10;
    localparam logic [1:0] ST_DEASSERT = 2'b11;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            result = result + 1;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/full_handshake_tx_sync_fifo.sv
// Small synchronous FIFO; DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo
    import full_handshake_tx_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            rd_data,
    output logic [clog2(DEPTH):0]    count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // A push while full is dropped even if a pop happens in the same cycle.
    always_comb begin
        push_ok = push & ~full;
        pop_ok  = pop & ~empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (!push_ok && pop_ok) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);

endmodule

// File: rtl/full_handshake_tx.sv
// Four-phase request/acknowledge transmitter fed by a local FIFO.
// ack_i is asynchronous and is only used after the two-flop synchroniser.
module full_handshake_tx
    import full_handshake_tx_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    output logic          full_o,
    output logic          idle_o,
    output logic          done_o,
    output logic          ovf_o,
    output logic          req_o,
    output logic [DW-1:0] req_data_o,
    input  logic          ack_i
);

    logic                  ack_d;
    logic                  ack_s;
    logic [1:0]            state;
    logic                  pop;
    logic [DW-1:0]         rd_data;
    logic [clog2(DEPTH):0] fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_i),
        .push_data (push_data_i),
        .pop       (pop),
        .rd_data   (rd_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_d <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_d <= ack_i;
            ack_s <= ack_d;
        end
    end

    // A stale high ack must be seen low before a new word is launched.
    always_comb begin
        pop = (state == ST_IDLE) & ~fifo_empty & ~ack_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_o      <= 1'b0;
            req_data_o <= '0;
            done_o     <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            ovf_o  <= push_i & fifo_full;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        req_data_o <= rd_data;
                        req_o      <= 1'b1;
                        state      <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (ack_s) begin
                        req_o <= 1'b0;
                        state <= ST_DEASSERT;
                    end
                end
                ST_DEASSERT: begin
                    if (!ack_s) begin
                        done_o <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    req_o <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign full_o = fifo_full;
    assign idle_o = (state == ST_IDLE) & (fifo_count == '0) & ~ack_s;

endmodule

// File: tb/tb_full_handshake_tx.sv
// Directed bench for full_handshake_tx with a simple four-phase receiver model.
module tb_full_handshake_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push_i = 1'b0;
    logic [31:0] push_data_i = '0;
    logic        full_o;
    logic        idle_o;
    logic        done_o;
    logic        ovf_o;
    logic        req_o;
    logic [31:0] req_data_o;
    logic        ack_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    full_handshake_tx #(.DW(32), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_i),
        .push_data_i (push_data_i),
        .full_o      (full_o),
        .idle_o      (idle_o),
        .done_o      (done_o),
        .ovf_o       (ovf_o),
        .req_o       (req_o),
        .req_data_o  (req_data_o),
        .ack_i       (ack_i)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_o === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic level, input string name);
        int n;
        n = 0;
        while (req_o !== level && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (req_o !== level) begin
            errors++;
            $display("FAIL %s: req_o=%b required %b (timeout)", name, req_o, level);
        end
    endtask

    task automatic rx_transfer(input logic [31:0] exp, input string name);
        int n;
        wait_req(1'b1, {name, "_req_rise"});
        checks++;
        if (req_data_o !== exp) begin
            errors++;
            $display("FAIL %s_data: req_data_o=%h required %h", name, req_data_o, exp);
        end
        repeat (3) tick();
        ack_i = 1'b1;
        wait_req(1'b0, {name, "_req_fall"});
        checks++;
        if (req_data_o !== exp) begin
            errors++;
            $display("FAIL %s_data_held: req_data_o=%h required %h", name, req_data_o, exp);
        end
        repeat (3) tick();
        ack_i = 1'b0;
        n = 0;
        while (done_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: done_o=%b required 1 (timeout)", name, done_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({req_o, done_o, ovf_o, full_o, idle_o} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_flags: req,done,ovf,full,idle=%b required 00001",
                     {req_o, done_o, ovf_o, full_o, idle_o});
        end
        checks++;
        if (req_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: req_data_o=%h required 00000000", req_data_o);
        end
    endtask

    task automatic test_single_word();
        int d0;
        d0 = done_cnt;
        push_i = 1'b1;
        push_data_i = 32'hDEADBEEF;
        tick();
        push_i = 1'b0;
        checks++;
        if (req_o !== 1'b0) begin
            errors++;
            $display("FAIL single_req_early: req_o=%b required 0", req_o);
        end
        tick();
        checks++;
        if (req_o !== 1'b1 || req_data_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_req_latency: req_o=%b data=%h required 1 deadbeef", req_o, req_data_o);
        end
        rx_transfer(32'hDEADBEEF, "single");
        tick();
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL single_done_count: got %0d required 1", done_cnt - d0);
        end
        checks++;
        if (idle_o !== 1'b1 || done_o !== 1'b0 || req_data_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_after: idle=%b done=%b data=%h required 1 0 deadbeef",
                     idle_o, done_o, req_data_o);
        end
    endtask

    task automatic test_burst_full();
        logic exp_full [6];
        exp_full = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            push_i = 1'b1;
            push_data_i = 32'(i + 1);
            tick();
            checks++;
            if (full_o !== exp_full[i]) begin
                errors++;
                $display("FAIL burst_full_%0d: full_o=%b required %b", i + 1, full_o, exp_full[i]);
            end
        end
        push_i = 1'b0;
        checks++;
        if (ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL burst_ovf: ovf_o=%b required 1", ovf_o);
        end
        tick();
        checks++;
        if (ovf_o !== 1'b0 || full_o !== 1'b1) begin
            errors++;
            $display("FAIL burst_ovf_pulse: ovf=%b full=%b required 0 1", ovf_o, full_o);
        end
        for (int i = 1; i <= 5; i++) begin
            rx_transfer(32'(i), $sformatf("burst%0d", i));
        end
        repeat (4) tick();
        checks++;
        if (req_o !== 1'b0 || idle_o !== 1'b1) begin
            errors++;
            $display("FAIL burst_drained: req=%b idle=%b required 0 1", req_o, idle_o);
        end
    endtask

    task automatic test_wrap();
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 10; i++) begin
            push_i = 1'b1;
            push_data_i = 32'hA000_0000 + 32'(i);
            tick();
            push_i = 1'b0;
            rx_transfer(32'hA000_0000 + 32'(i), $sformatf("wrap%0d", i));
        end
        tick();
        checks++;
        if (done_cnt - d0 !== 10 || idle_o !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done_count: got %0d idle=%b required 10 1", done_cnt - d0, idle_o);
        end
    endtask

    task automatic test_push_pop_same_cycle();
        push_i = 1'b1;
        push_data_i = 32'h9;
        tick();
        push_data_i = 32'hA;
        tick();
        push_i = 1'b0;
        checks++;
        if (dut.fifo_count !== 3'd1 || req_o !== 1'b1 || req_data_o !== 32'h9) begin
            errors++;
            $display("FAIL pushpop_count: count=%0d req=%b data=%h required 1 1 00000009",
                     dut.fifo_count, req_o, req_data_o);
        end
        rx_transfer(32'h9, "pushpop_first");
        rx_transfer(32'hA, "pushpop_second");
    endtask

    task automatic test_stale_ack();
        logic early;
        ack_i = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (idle_o !== 1'b1) begin
            errors++;
            $display("FAIL stale_idle_after_reset: idle_o=%b required 1", idle_o);
        end
        repeat (3) tick();
        checks++;
        if (idle_o !== 1'b0) begin
            errors++;
            $display("FAIL stale_idle_ack_high: idle_o=%b required 0", idle_o);
        end
        push_i = 1'b1;
        push_data_i = 32'h55;
        tick();
        push_i = 1'b0;
        early = 1'b0;
        repeat (4) begin
            tick();
            if (req_o !== 1'b0) early = 1'b1;
        end
        ack_i = 1'b0;
        tick();
        if (req_o !== 1'b0) early = 1'b1;
        tick();
        if (req_o !== 1'b0) early = 1'b1;
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL stale_req_blocked: req_o rose early=%b required 0", early);
        end
        tick();
        checks++;
        if (req_o !== 1'b1 || req_data_o !== 32'h55) begin
            errors++;
            $display("FAIL stale_req_release: req=%b data=%h required 1 00000055", req_o, req_data_o);
        end
        rx_transfer(32'h55, "stale");
    endtask

    task automatic test_reset_mid_assert();
        int d0;
        push_i = 1'b1;
        push_data_i = 32'h77;
        tick();
        push_data_i = 32'h78;
        tick();
        push_i = 1'b0;
        checks++;
        if (req_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_req_up: req_o=%b required 1", req_o);
        end
        ack_i = 1'b1;
        tick();
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        checks++;
        if (req_o !== 1'b0 || full_o !== 1'b0 || done_o !== 1'b0 || idle_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_reset_edge: req=%b full=%b done=%b idle=%b required 0 0 0 1",
                     req_o, full_o, done_o, idle_o);
        end
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (idle_o !== 1'b0 || req_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ack_pending: idle=%b req=%b required 0 0", idle_o, req_o);
        end
        ack_i = 1'b0;
        tick();
        tick();
        checks++;
        if (idle_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_idle_return: idle_o=%b required 1", idle_o);
        end
        repeat (3) tick();
        checks++;
        if (done_cnt !== d0 || req_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_done: done pulses=%0d req=%b required 0 0", done_cnt - d0, req_o);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_single_word();
        test_burst_full();
        test_wrap();
        test_push_pop_same_cycle();
        test_stale_ack();
        test_reset_mid_assert();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
